mem_request_port: RTL and testbench

Initiator end of the memory-controller FIFO protocol. Accepts read/write requests from the simulator-side logic over a valid/ready handshake, assigns a transaction ID (TID), packs and pushes the request into the request FIFO drained by `mem_controller`, then pops `{TID, data}` responses from the response FIFO, matches them against an outstanding-TID table and returns them upstream. One instance per controller lane.

---
 rtl/mem_request_port_if.sv | 66 ++++++
 rtl/mem_request_port.sv | 205 ++++++++++++++++++++
 tb/tb_mem_request_port.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_request_port_if.sv
// Bundle of the upstream request/response handshakes and the request/response
// FIFO connections of one memory-controller lane. The master modport is the
// view of mem_request_port; the slave modport is the view of its environment.
interface mem_request_port_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 31,
  parameter int TID_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = 3
) ();

  // Upstream request handshake
  logic                                      req_valid;
  logic                                      req_ready;
  logic                                      req_rw;
  logic [ADDR_WIDTH-1:0]                     req_addr;
  logic [DATA_WIDTH-1:0]                     req_data;

  // Request FIFO push side
  logic                                      write_ctr;
  logic [TID_WIDTH+1+ADDR_WIDTH+DATA_WIDTH-1:0] req_fifo_data;
  logic                                      full_signal;

  // Response FIFO pop side
  logic                                      read_ctr;
  logic [TID_WIDTH+DATA_WIDTH-1:0]           rsp_fifo_data;
  logic                                      empty_signal;

  // Upstream response handshake
  logic                                      rsp_valid;
  logic                                      rsp_ready;
  logic [TID_WIDTH-1:0]                      rsp_tid;
  logic [DATA_WIDTH-1:0]                     rsp_data;

  // Status
  logic [CNT_WIDTH-1:0]                      outstanding;
  logic                                      orphan_pulse;

  // Outstanding-table depth is carried here so both sides agree on it
  localparam int TABLE_DEPTH = MAX_OUTSTANDING;

  modport master (
    input  req_valid, req_rw, req_addr, req_data,
    output req_ready,
    output write_ctr, req_fifo_data,
    input  full_signal,
    output read_ctr,
    input  rsp_fifo_data, empty_signal,
    output rsp_valid, rsp_tid, rsp_data,
    input  rsp_ready,
    output outstanding, orphan_pulse
  );

  modport slave (
    output req_valid, req_rw, req_addr, req_data,
    input  req_ready,
    input  write_ctr, req_fifo_data,
    output full_signal,
    input  read_ctr,
    output rsp_fifo_data, empty_signal,
    input  rsp_valid, rsp_tid, rsp_data,
    output rsp_ready,
    input  outstanding, orphan_pulse
  );

endinterface

// File: rtl/mem_request_port.sv
// Initiator end of the memory-controller FIFO protocol. Requests are tagged
// with a transaction ID and pushed into the request FIFO in the accept cycle;
// responses are popped from the response FIFO, matched against the table of
// outstanding IDs and presented upstream until consumed. Responses carrying an
// unknown ID are dropped and flagged with a one-cycle orphan pulse.
module mem_request_port #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 31,
  parameter int TID_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = 3
) (
  input logic            clk,
  input logic            reset,
  mem_request_port_if.master bus
);

  localparam int IDX_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } rsp_state_e;

  // Request side state
  logic [TID_WIDTH-1:0]       next_tid_r;
  logic [MAX_OUTSTANDING-1:0] tbl_valid_r;
  logic [TID_WIDTH-1:0]       tbl_tid_r [MAX_OUTSTANDING];
  logic [CNT_WIDTH-1:0]       outstanding_r;

  // Response side state
  rsp_state_e                 state_r;
  rsp_state_e                 next_state_s;
  logic                       rsp_valid_r;
  logic [TID_WIDTH-1:0]       rsp_tid_r;
  logic [DATA_WIDTH-1:0]      rsp_data_r;
  logic                       orphan_pulse_r;

  // Combinational helpers
  logic                       tid_busy_s;
  logic [IDX_WIDTH-1:0]       free_idx_s;
  logic                       hit_s;
  logic [IDX_WIDTH-1:0]       hit_idx_s;
  logic                       room_s;
  logic                       req_ready_s;
  logic                       accept_s;
  logic                       read_en_s;
  logic                       fetch_hit_s;
  logic                       fetch_miss_s;
  logic [TID_WIDTH-1:0]       fetch_tid_s;
  logic [DATA_WIDTH-1:0]      fetch_data_s;

  assign fetch_tid_s  = bus.rsp_fifo_data[TID_WIDTH+DATA_WIDTH-1 -: TID_WIDTH];
  assign fetch_data_s = bus.rsp_fifo_data[DATA_WIDTH-1:0];

  // Table scan: lowest free slot, collision of next_tid, and CAM hit on the fetched TID
  always_comb begin
    tid_busy_s = 1'b0;
    free_idx_s = '0;
    hit_s      = 1'b0;
    hit_idx_s  = '0;
    // Scan high-to-low so the last assignment wins with the lowest index
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (tbl_valid_r[i]) begin
        if (tbl_tid_r[i] == next_tid_r) begin
          tid_busy_s = 1'b1;
        end else begin
          tid_busy_s = tid_busy_s;
        end
        if (tbl_tid_r[i] == fetch_tid_s) begin
          hit_s     = 1'b1;
          hit_idx_s = IDX_WIDTH'(i);
        end else begin
          hit_s     = hit_s;
          hit_idx_s = hit_idx_s;
        end
      end else begin
        free_idx_s = IDX_WIDTH'(i);
      end
    end
  end

  // Zero-latency push: the request goes straight into the FIFO when accepted.
  // The freed slot of a same-cycle FETCH hit is not visible here because the
  // scan above only looks at the registered table.
  assign room_s        = (outstanding_r < CNT_WIDTH'(MAX_OUTSTANDING));
  assign req_ready_s   = !reset && !bus.full_signal && room_s && !tid_busy_s;
  assign accept_s      = bus.req_valid && req_ready_s;
  assign bus.req_ready = req_ready_s;
  assign bus.write_ctr = accept_s;
  assign bus.req_fifo_data = {next_tid_r, bus.req_rw, bus.req_addr, bus.req_data};

  assign fetch_hit_s  = (state_r == ST_FETCH) && hit_s;
  assign fetch_miss_s = (state_r == ST_FETCH) && !hit_s;

  // Response FSM next-state and FIFO pop strobe
  always_comb begin
    next_state_s = state_r;
    read_en_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!bus.empty_signal && !reset) begin
          read_en_s    = 1'b1;
          next_state_s = ST_FETCH;
        end else begin
          read_en_s    = 1'b0;
          next_state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (hit_s) begin
          next_state_s = ST_HOLD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (bus.rsp_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_HOLD;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  assign bus.read_ctr = read_en_s;

  // Response FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Registered upstream response outputs and orphan flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_r    <= 1'b0;
      rsp_tid_r      <= '0;
      rsp_data_r     <= '0;
      orphan_pulse_r <= 1'b0;
    end else begin
      rsp_valid_r    <= (next_state_s == ST_HOLD);
      orphan_pulse_r <= fetch_miss_s;
      if (fetch_hit_s) begin
        rsp_tid_r  <= fetch_tid_s;
        rsp_data_r <= fetch_data_s;
      end
    end
  end

  // Outstanding table: allocate on accept, free on FETCH hit (never the same slot)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tbl_valid_r <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tbl_tid_r[i] <= '0;
      end
    end else begin
      if (accept_s) begin
        tbl_valid_r[free_idx_s] <= 1'b1;
        tbl_tid_r[free_idx_s]   <= next_tid_r;
      end
      if (fetch_hit_s) begin
        tbl_valid_r[hit_idx_s] <= 1'b0;
      end
    end
  end

  // TID counter, wraps naturally at 2^TID_WIDTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_tid_r <= '0;
    end else if (accept_s) begin
      next_tid_r <= next_tid_r + TID_WIDTH'(1);
    end
  end

  // Outstanding count: net of this cycle's allocate and free
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding_r <= '0;
    end else begin
      case ({accept_s, fetch_hit_s})
        2'b10:   outstanding_r <= outstanding_r + CNT_WIDTH'(1);
        2'b01:   outstanding_r <= outstanding_r - CNT_WIDTH'(1);
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  assign bus.rsp_valid    = rsp_valid_r;
  assign bus.rsp_tid      = rsp_tid_r;
  assign bus.rsp_data     = rsp_data_r;
  assign bus.outstanding  = outstanding_r;
  assign bus.orphan_pulse = orphan_pulse_r;

endmodule

// File: tb/tb_mem_request_port.sv
// Directed testbench for mem_request_port. Inputs change 1 time unit after a
// rising edge; outputs are sampled before the next rising edge.
module tb_mem_request_port;

  localparam int DW = 32;
  localparam int AW = 31;
  localparam int TW = 16;
  localparam int MO = 4;
  localparam int CW = 3;
  localparam int RW = TW + 1 + AW + DW;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mem_request_port_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TID_WIDTH(TW),
                        .MAX_OUTSTANDING(MO), .CNT_WIDTH(CW)) bus ();

  mem_request_port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TID_WIDTH(TW),
                     .MAX_OUTSTANDING(MO), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid     = 1'b0;
    bus.req_rw        = 1'b0;
    bus.req_addr      = '0;
    bus.req_data      = '0;
    bus.full_signal   = 1'b0;
    bus.rsp_fifo_data = '0;
    bus.empty_signal  = 1'b1;
    bus.rsp_ready     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    bus.req_valid    = 1'b1;
    bus.empty_signal = 1'b0;
    tick();
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
    checks++; if (bus.write_ctr !== 1'b0) begin errors++; $display("FAIL reset_write_ctr: got %b want 0", bus.write_ctr); end
    checks++; if (bus.read_ctr !== 1'b0) begin errors++; $display("FAIL reset_read_ctr: got %b want 0", bus.read_ctr); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_tid !== 16'h0000) begin errors++; $display("FAIL reset_rsp_tid: got %h want 0", bus.rsp_tid); end
    checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); end
    checks++; if (bus.outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", bus.outstanding); end
    checks++; if (bus.orphan_pulse !== 1'b0) begin errors++; $display("FAIL reset_orphan: got %b want 0", bus.orphan_pulse); end
    idle_inputs();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_first_read();
    logic [RW-1:0] exp_word;
    exp_word = {16'h0000, 1'b0, 31'h0000000F, 32'h00000000};
    bus.req_valid = 1'b1;
    bus.req_rw    = 1'b0;
    bus.req_addr  = 31'h0000000F;
    bus.req_data  = 32'h00000000;
    #1;
    checks++; if (bus.write_ctr !== 1'b1) begin errors++; $display("FAIL first_write_ctr: got %b want 1", bus.write_ctr); end
    checks++; if (bus.req_fifo_data !== exp_word) begin errors++; $display("FAIL first_fifo_word: got %h want %h", bus.req_fifo_data, exp_word); end
    tick();
    bus.req_valid = 1'b0;
    #1;
    checks++; if (bus.write_ctr !== 1'b0) begin errors++; $display("FAIL first_write_ctr_drop: got %b want 0", bus.write_ctr); end
    checks++; if (bus.outstanding !== 3'd1) begin errors++; $display("FAIL first_outstanding: got %0d want 1", bus.outstanding); end
  endtask

  task automatic test_response();
    bus.rsp_fifo_data = {16'h0000, 32'hDEADBEEF};
    bus.empty_signal  = 1'b0;
    #1;
    checks++; if (bus.read_ctr !== 1'b1) begin errors++; $display("FAIL rsp_read_ctr_n: got %b want 1", bus.read_ctr); end
    tick();
    bus.empty_signal = 1'b1;
    #1;
    checks++; if (bus.read_ctr !== 1'b0) begin errors++; $display("FAIL rsp_read_ctr_n1: got %b want 0", bus.read_ctr); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_valid_n1: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.outstanding !== 3'd1) begin errors++; $display("FAIL rsp_outstanding_n1: got %0d want 1", bus.outstanding); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rsp_valid_n2: got %b want 1", bus.rsp_valid); end
    checks++; if (bus.rsp_tid !== 16'h0000) begin errors++; $display("FAIL rsp_tid_n2: got %h want 0000", bus.rsp_tid); end
    checks++; if (bus.rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rsp_data_n2: got %h want deadbeef", bus.rsp_data); end
    checks++; if (bus.outstanding !== 3'd0) begin errors++; $display("FAIL rsp_outstanding_n2: got %0d want 0", bus.outstanding); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_valid_after_take: got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'b1;
      bus.req_rw    = 1'b1;
      bus.req_addr  = AW'(32'h100 + i);
      bus.req_data  = DW'(32'hA000 + i);
      #1;
      checks++; if (bus.req_fifo_data[RW-1 -: TW] !== TW'(i) || bus.write_ctr !== 1'b1) begin
        errors++; $display("FAIL fill_tid_%0d: got tid %h wr %b want tid %h wr 1", i, bus.req_fifo_data[RW-1 -: TW], bus.write_ctr, i);
      end
      tick();
    end
    #1;
    checks++; if (bus.outstanding !== 3'd4) begin errors++; $display("FAIL fill_outstanding: got %0d want 4", bus.outstanding); end
    checks++; if (bus.req_ready !== 1'b0 || bus.write_ctr !== 1'b0) begin errors++; $display("FAIL fill_blocked: got ready %b wr %b want 0 0", bus.req_ready, bus.write_ctr); end
    bus.rsp_fifo_data = {16'h0002, 32'h00000055};
    bus.empty_signal  = 1'b0;
    tick();
    bus.empty_signal = 1'b1;
    tick();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_back: got %b want 1", bus.req_ready); end
    checks++; if (bus.req_fifo_data[RW-1 -: TW] !== 16'h0004) begin errors++; $display("FAIL fill_new_tid: got %h want 0004", bus.req_fifo_data[RW-1 -: TW]); end
    checks++; if (bus.outstanding !== 3'd3) begin errors++; $display("FAIL fill_outstanding_freed: got %0d want 3", bus.outstanding); end
    checks++; if (bus.rsp_tid !== 16'h0002 || bus.rsp_data !== 32'h00000055) begin errors++; $display("FAIL fill_rsp: got %h/%h want 0002/00000055", bus.rsp_tid, bus.rsp_data); end
    tick();
    bus.req_valid = 1'b0;
    #1;
    checks++; if (bus.outstanding !== 3'd4) begin errors++; $display("FAIL fill_refill: got %0d want 4", bus.outstanding); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_orphan();
    bus.rsp_fifo_data = {16'h0123, 32'h12345678};
    bus.empty_signal  = 1'b0;
    tick();
    bus.empty_signal = 1'b1;
    checks++; if (bus.orphan_pulse !== 1'b0) begin errors++; $display("FAIL orphan_early: got %b want 0", bus.orphan_pulse); end
    tick();
    checks++; if (bus.orphan_pulse !== 1'b1) begin errors++; $display("FAIL orphan_pulse: got %b want 1", bus.orphan_pulse); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL orphan_rsp_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.outstanding !== 3'd4) begin errors++; $display("FAIL orphan_outstanding: got %0d want 4", bus.outstanding); end
    tick();
    checks++; if (bus.orphan_pulse !== 1'b0) begin errors++; $display("FAIL orphan_one_cycle: got %b want 0", bus.orphan_pulse); end
  endtask

  task automatic test_full_stall();
    do_reset();
    bus.full_signal = 1'b1;
    bus.req_valid   = 1'b1;
    bus.req_addr    = 31'h00000200;
    #1;
    checks++; if (bus.write_ctr !== 1'b0) begin errors++; $display("FAIL full_write_ctr: got %b want 0", bus.write_ctr); end
    tick();
    checks++; if (bus.outstanding !== 3'd0) begin errors++; $display("FAIL full_outstanding: got %0d want 0", bus.outstanding); end
    bus.full_signal = 1'b0;
    #1;
    checks++; if (bus.write_ctr !== 1'b1 || bus.req_fifo_data[RW-1 -: TW] !== 16'h0000) begin
      errors++; $display("FAIL full_release: got wr %b tid %h want 1 0000", bus.write_ctr, bus.req_fifo_data[RW-1 -: TW]);
    end
    tick();
    bus.req_valid = 1'b0;
    checks++; if (bus.outstanding !== 3'd1) begin errors++; $display("FAIL full_accepted: got %0d want 1", bus.outstanding); end
  endtask

  task automatic test_back_to_back();
    // TID 0 is outstanding; pop its response while pushing TID 1 in the FETCH cycle
    bus.rsp_fifo_data = {16'h0000, 32'h0BADF00D};
    bus.empty_signal  = 1'b0;
    tick();
    bus.empty_signal = 1'b1;
    bus.req_valid    = 1'b1;
    bus.req_addr     = 31'h00000020;
    #1;
    checks++; if (bus.write_ctr !== 1'b1 || bus.req_fifo_data[RW-1 -: TW] !== 16'h0001) begin
      errors++; $display("FAIL b2b_push: got wr %b tid %h want 1 0001", bus.write_ctr, bus.req_fifo_data[RW-1 -: TW]);
    end
    tick();
    bus.req_valid = 1'b0;
    checks++; if (bus.outstanding !== 3'd1) begin errors++; $display("FAIL b2b_outstanding: got %0d want 1", bus.outstanding); end
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0BADF00D) begin errors++; $display("FAIL b2b_rsp: got %b/%h want 1/0badf00d", bus.rsp_valid, bus.rsp_data); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_hold_reset();
    // TID 1 is outstanding
    bus.rsp_fifo_data = {16'h0001, 32'hCAFEF00D};
    bus.empty_signal  = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_tid !== 16'h0001 || bus.rsp_data !== 32'hCAFEF00D || bus.read_ctr !== 1'b0) begin
        errors++; $display("FAIL hold_stable_%0d: got v %b tid %h data %h rd %b want 1 0001 cafef00d 0", i, bus.rsp_valid, bus.rsp_tid, bus.rsp_data, bus.read_ctr);
      end
      tick();
    end
    reset = 1'b1;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_tid !== 16'h0000 || bus.rsp_data !== 32'h0) begin
      errors++; $display("FAIL hold_reset_rsp: got %b %h %h want 0 0000 00000000", bus.rsp_valid, bus.rsp_tid, bus.rsp_data);
    end
    checks++; if (bus.read_ctr !== 1'b0 || bus.req_ready !== 1'b0 || bus.write_ctr !== 1'b0) begin
      errors++; $display("FAIL hold_reset_ctl: got rd %b rdy %b wr %b want 0 0 0", bus.read_ctr, bus.req_ready, bus.write_ctr);
    end
    checks++; if (bus.outstanding !== 3'd0 || bus.orphan_pulse !== 1'b0) begin
      errors++; $display("FAIL hold_reset_status: got %0d %b want 0 0", bus.outstanding, bus.orphan_pulse);
    end
    idle_inputs();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_first_read();
    test_response();
    test_fill();
    test_orphan();
    test_full_stall();
    test_back_to_back();
    test_hold_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
